// File: rtl/vector_encoder.sv
// Position-code to vector encoder: leading one at bit k-1, bursts of 1..16 beats.
// Define VECTOR_ENCODER_LFSR_FILL_EN to fill bits below the leading one from a Galois LFSR.
module vector_encoder #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  pos_in,
  input  logic [3:0]  burst_len,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        pos_err
);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e      state_q, state_d;
  logic [5:0]  code_q, code_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [5:0]  code_in;
  logic [31:0] fill;

  assign code_in = (pos_in > 6'd32) ? 6'd32 : pos_in;

  function automatic logic [31:0] make_vec(input logic [5:0] code, input logic [31:0] f);
    logic [31:0] one;
    if (code == 6'd0) return 32'h0;
    one = 32'd1 << (code - 6'd1);
    return one | (f & (one - 32'd1));
  endfunction

`ifdef VECTOR_ENCODER_LFSR_FILL_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic        load;

  // Advances once per data_out load; each vector uses the pre-advance value.
  assign load = ((state_q == StIdle) && pos_valid) ||
                ((state_q == StEmit) && data_ready && (cnt_q != 4'd0));
  assign fill = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign fill = 32'h0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pos_valid) begin
          code_d  = code_in;
          cnt_d   = burst_len;
          data_d  = make_vec(code_in, fill);
          err_d   = (pos_in > 6'd32);
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (data_ready) begin
          if (cnt_q != 4'd0) begin
            cnt_d  = cnt_q - 4'd1;
            data_d = make_vec(code_q, fill);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      code_q  <= 6'd0;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign pos_ready  = (state_q == StIdle);
  assign data_valid = (state_q == StEmit);
  assign data_out   = data_q;
  assign pos_err    = err_q;

endmodule

// File: tb/tb_vector_encoder.sv
// Self-checking bench for vector_encoder: queue-based scoreboard plus hand-computed vectors.
module tb_vector_encoder;
  localparam logic [31:0] Seed = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  pos_in = 6'd0;
  logic [3:0]  burst_len = 4'd0;
  logic        pos_valid = 1'b0;
  logic        pos_ready;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        pos_err;

  always #5 clk = ~clk;

  vector_encoder #(.LFSR_SEED(Seed)) dut (
    .clk(clk), .rst(rst), .pos_in(pos_in), .burst_len(burst_len), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .pos_err(pos_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  int          code_q[$];
  logic [31:0] m_lfsr = Seed;
  bit          m_err = 0;
  bit          m_known = 0;
  bit          m_rst_zero = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] golden_vec(input int code, input logic [31:0] l);
    logic [63:0] one;
    if (code == 0) return 32'h0;
    one = 64'd1 << (code - 1);
`ifdef VECTOR_ENCODER_LFSR_FILL_EN
    return 32'(one | ({32'h0, l} & (one - 64'd1)));
`else
    return 32'(one) | (l & 32'h0);
`endif
  endfunction

  function automatic int lead_one(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit was_empty;
    int code;
    if (!rst) begin
      exp_q.delete();
      code_q.delete();
      m_lfsr = Seed;
      m_err = 0;
      m_known = 1;
      m_rst_zero = 1;
    end else begin
      was_empty = (exp_q.size() == 0);
      m_err = 0;
      if (!was_empty && data_ready) begin
        void'(exp_q.pop_front());
        void'(code_q.pop_front());
      end else if (was_empty && pos_valid) begin
        code = (int'(pos_in) > 32) ? 32 : int'(pos_in);
        m_err = (int'(pos_in) > 32);
        m_rst_zero = 0;
        for (int i = 0; i <= int'(burst_len); i++) begin
          exp_q.push_back(golden_vec(code, m_lfsr));
          code_q.push_back(code);
          m_lfsr = lfsr_next(m_lfsr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("pos_ready", {31'h0, pos_ready}, {31'h0, exp_q.size() == 0});
      check("data_valid", {31'h0, data_valid}, {31'h0, exp_q.size() != 0});
      check("pos_err", {31'h0, pos_err}, {31'h0, m_err});
      if (exp_q.size() != 0) begin
        check("data_out", data_out, exp_q[0]);
        check("lead_one", lead_one(data_out), code_q[0]);
      end else if (m_rst_zero) begin
        check("data_out_reset", data_out, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 0;
  always @(negedge clk) if (rand_ready) data_ready = ($urandom_range(0, 3) != 0);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pos_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns at the negedge after acceptance (first beat visible).
  task automatic send(input logic [5:0] p, input logic [3:0] b);
    int t = 0;
    @(negedge clk);
    while (!pos_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("pos_ready_timeout", 32'd0, 32'd1);
    pos_in = p;
    burst_len = b;
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!pos_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] lit32 [4];

  initial begin
`ifdef VECTOR_ENCODER_LFSR_FILL_EN
    lit32[0] = 32'hACE1_0001;
    lit32[1] = 32'hD650_8003;
    lit32[2] = 32'hEB08_4002;
    lit32[3] = 32'hF584_2001;
`else
    for (int i = 0; i < 4; i++) lit32[i] = 32'h8000_0000;
`endif

    // Reset release and single-beat code 1
    do_reset();
    @(negedge clk);
    check("lit_reset_ready", {31'h0, pos_ready}, 32'd1);
    check("lit_reset_valid", {31'h0, data_valid}, 32'd0);
    data_ready = 1'b1;
    send(6'd1, 4'd0);
    check("lit_code1", data_out, 32'h0000_0001);
    @(negedge clk);
    check("lit_code1_idle", {31'h0, pos_ready}, 32'd1);

    // Code 32, four beats from a fresh LFSR
    do_reset();
    send(6'd32, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check("lit_code32_beat", data_out, lit32[i]);
      @(negedge clk);
    end
    check("lit_code32_done", {31'h0, pos_ready}, 32'd1);

    // Code 0 and out-of-range code
    send(6'd0, 4'd0);
    check("lit_code0", data_out, 32'h0);
    wait_idle();
    send(6'd45, 4'd0);
    check("lit_code45_err", {31'h0, pos_err}, 32'd1);
    check("lit_code45_msb", {31'h0, data_out[31]}, 32'd1);
    wait_idle();

    // Backpressure mid-burst with ignored pos_valid pulses
    send(6'd5, 4'd3);
    @(negedge clk);
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pos_in = 6'd20;
      burst_len = 4'd9;
      pos_valid = i[0];
      @(negedge clk);
    end
    pos_valid = 1'b0;
    data_ready = 1'b1;
    wait_idle();

    // Reset during beat 2 of an 8-beat burst
    send(6'd3, 4'd7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("lit_abort_valid", {31'h0, data_valid}, 32'd0);
    check("lit_abort_data", data_out, 32'h0);
    rst = 1'b1;
    send(6'd32, 4'd0);
    check("lit_abort_seed", data_out, lit32[0]);
    wait_idle();

    // Random positions with random sink backpressure
    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      send(6'($urandom_range(0, 63)), 4'($urandom_range(0, 3)));
    end
    wait_idle();
    rand_ready = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
